// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// with input synchronisation, false-start rejection and error/break reporting.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic             ODD_PARITY = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    // Synchroniser resets to all ones so the line reads idle straight out of reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous
            // stage's old value, so the chain really is SYNC_STAGES flops deep.
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_q;
    logic                 frm_err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            // NOTE: the shift register is reset as well; it is a handful of
            // flops, not a RAM, and a known value keeps simulation X-free.
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        idx        <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            par_err_q <= 1'b0;
                            frm_err_q <= 1'b0;
                            stop_idx  <= 1'b0;
                            state     <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        par_err_q <= ((^shreg) ^ rx_s) != ODD_PARITY;
                        state     <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // The final stop sample resolves the frame: outcome pulses are
                // registered here so they appear in the following cycle.
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        stop_idx <= stop_idx + 1'b1;
                        if (stop_idx == STOP_LAST) begin
                            if (!rx_s || frm_err_q) begin
                                frame_err_o <= 1'b1;
                            end else if (par_err_q) begin
                                parity_err_o <= 1'b1;
                            end else begin
                                data_o  <= shreg;
                                valid_o <= 1'b1;
                            end
                            if (rx_s) begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end else begin
                                state   <= BREAK;
                                break_o <= 1'b1;
                            end
                        end else if (!rx_s) begin
                            frm_err_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        state   <= IDLE;
                        break_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    break_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised serial receiver that succeeds the fixed 8N1 UART receiver in the Pong top level. It supports configurable data width, parity mode and stop-bit count. It provides input synchronisation, false-start rejection, and parity, framing and break detection. It sits between the board UART pin and the game-control logic; the per-byte valid pulse starts or controls the game.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per bit (25 MHz / 115200); must be >= 4.
- DATA_BITS, 8, payload bits per frame; range 5..9; sent LSB first.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits checked per frame; 1 or 2.
- SYNC_STAGES, 2, flip-flops in the rx input synchroniser; >= 2.

Ports:
- clk_i  in  1  system clock, 25 MHz.
- rst_n_i  in  1  reset, synchronous, active-low.
- rx_i  in  1  asynchronous serial line; idle high.
- data_o  out  DATA_BITS  last good received word; held until the next good frame.
- valid_o  out  1  one-cycle pulse; a good frame has been received into data_o.
- parity_err_o  out  1  one-cycle pulse; frame ended with a parity mismatch.
- frame_err_o  out  1  one-cycle pulse; a stop bit was sampled low.
- break_o  out  1  level; high while the line is held low after a framing error.
- busy_o  out  1  high from start-bit detection until the FSM returns to IDLE.

Behaviour:
- Interface: one clock, clk_i. Reset rst_n_i is synchronous and active-low.
- Reset values: data_o = 0; valid_o, parity_err_o, frame_err_o, break_o and busy_o = 0. Synchroniser flops reset to 1, so the line reads idle. FSM enters IDLE. Reset asserted mid-frame aborts the frame and produces no pulse.
- rx_s is the output of the SYNC_STAGES flop chain. All decisions use rx_s only.
- Bit counter width is $clog2(CLKS_PER_BIT). Bit index width is $clog2(DATA_BITS).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when rx_s = 0, go to START, clear the counter and set busy_o.
- START: count to (CLKS_PER_BIT-1)/2 (mid-bit), then resample rx_s.
  - rx_s = 1: false start. Return to IDLE with no outputs and busy_o low.
  - rx_s = 0: go to DATA.
- DATA: each time the counter reaches CLKS_PER_BIT-1, sample rx_s into the shift register at the current bit index (LSB first). After DATA_BITS samples:
  - go to PARITY if PARITY_MODE != 0;
  - otherwise go to STOP.
- PARITY: sample one bit after CLKS_PER_BIT cycles.
  - Mismatch when (XOR of the data bits XOR the parity bit) != (PARITY_MODE == 2).
  - The mismatch result is latched internally.
- STOP: sample STOP_BITS bits, CLKS_PER_BIT cycles apart. Any low sample sets the internal frame error flag.
- Frame end: the cycle after the final stop sample, exactly one outcome occurs.
  - Frame error: pulse frame_err_o. It takes priority; parity_err_o is suppressed and data_o is not updated.
  - Parity error only: pulse parity_err_o; data_o is not updated.
  - Clean frame: load data_o and pulse valid_o in the same cycle.
- After frame end:
  - if rx_s = 1, return to IDLE and drop busy_o;
  - if rx_s = 0, go to BREAK with break_o = 1.
- BREAK: stay until rx_s = 1, then return to IDLE. No retrigger occurs while the line is held low.
- Latency: a rx_i edge is visible on rx_s after SYNC_STAGES cycles. valid_o follows the centre of the last stop bit by 1 cycle.
- Back-to-back frames: a start bit arriving right after the stop centre is accepted, with no idle bit required.
- No flow control. data_o is overwritten by each good frame, and the consumer must capture it on valid_o.

Test Plan:
- 8N1 (defaults): send 0xA5, then 0x3C back-to-back with no idle gap.
  - Two valid_o pulses; data_o = 0xA5, then 0x3C.
  - No error pulses; busy_o stays low between frames.
- 8E1 (PARITY_MODE=1): send 0x55 with parity bit 0.
  - valid_o pulses and data_o = 0x55.
  - Resend 0x55 with parity bit 1: parity_err_o pulses, valid_o stays 0, data_o stays 0x55.
- False start: drive rx_i low for 50 cycles, then high (CLKS_PER_BIT=217).
  - No pulses occur; busy_o falls within 110 + SYNC_STAGES cycles.
- Framing error and break: send 0x12 with the stop bit low, then hold rx_i low for 5 bit times.
  - frame_err_o pulses once and break_o stays high until rx_i returns high.
  - A following good 0x34 yields valid_o with data_o = 0x34.
- 7O2 (DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2): send 0x7F with parity 0 and the second stop bit low.
  - frame_err_o pulses and valid_o stays 0.
  - Resend with both stop bits high: valid_o pulses and data_o = 0x7F.
- Reset mid-frame: assert rst_n_i for 1 cycle during data bit 3 of 0xFF.
  - All outputs read 0 on the next cycle and no pulse occurs for the aborted frame.
  - The next frame, 0x01, is received correctly.
